// File: rtl/periph_pkg.sv
// Shared types for the operand-entry / result-view peripheral: FSM states, glyph codes, IEEE-754 specials.
// No logic here; latency and backpressure belong to the modules that import it.
package periph_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_FULL = 2'd1,
        ST_VIEW = 2'd2
    } state_t;

    typedef logic [4:0] glyph_t;

    // Codes 0-15 are the hex digits, so A b C d E F double as the letter glyphs.
    localparam glyph_t G_A     = 5'd10;
    localparam glyph_t G_B     = 5'd11;
    localparam glyph_t G_C     = 5'd12;
    localparam glyph_t G_D     = 5'd13;
    localparam glyph_t G_E     = 5'd14;
    localparam glyph_t G_F     = 5'd15;
    localparam glyph_t G_R     = 5'd16;
    localparam glyph_t G_N     = 5'd17;
    localparam glyph_t G_I     = 5'd18;
    localparam glyph_t G_MINUS = 5'd19;
    localparam glyph_t G_BLANK = 5'd20;

    localparam logic [31:0] SPC_QNAN_POS = 32'h7FC0_0000;
    localparam logic [31:0] SPC_QNAN_NEG = 32'hFFC0_0000;
    localparam logic [31:0] SPC_INF_POS  = 32'h7F80_0000;
    localparam logic [31:0] SPC_INF_NEG  = 32'hFF80_0000;

    function automatic glyph_t hex_glyph(input logic [3:0] nib);
        return {1'b0, nib};
    endfunction

    function automatic glyph_t op_letter(input logic [1:0] k);
        case (k)
            2'd0:    return G_A;
            2'd1:    return G_B;
            2'd2:    return G_C;
            default: return G_D;
        endcase
    endfunction

endpackage

// File: rtl/periph_glyph7seg.sv
// Glyph code to active-low seven-segment pattern {g..a}.
// Purely combinational, zero latency; no flow control.
module periph_glyph7seg
    import periph_pkg::*;
(
    input  glyph_t     glyph,
    output logic [6:0] seg
);

    logic [6:0] lit;

    always_comb begin
        lit = 7'h00;
        case (glyph)
            5'd0:    lit = 7'h3F;
            5'd1:    lit = 7'h06;
            5'd2:    lit = 7'h5B;
            5'd3:    lit = 7'h4F;
            5'd4:    lit = 7'h66;
            5'd5:    lit = 7'h6D;
            5'd6:    lit = 7'h7D;
            5'd7:    lit = 7'h07;
            5'd8:    lit = 7'h7F;
            5'd9:    lit = 7'h6F;
            G_A:     lit = 7'h77;
            G_B:     lit = 7'h7C;
            G_C:     lit = 7'h39;
            G_D:     lit = 7'h5E;
            G_E:     lit = 7'h79;
            G_F:     lit = 7'h71;
            G_R:     lit = 7'h50;
            G_N:     lit = 7'h54;
            G_I:     lit = 7'h30;
            G_MINUS: lit = 7'h40;
            G_BLANK: lit = 7'h00;
            default: lit = 7'h00;
        endcase
    end

    assign seg = ~lit;

endmodule

// File: rtl/peripherals_multi.sv
// Pushbutton byte loader for NUM_OPS operands plus paged result viewer on four 7-segment digits.
// A press acts on the 3rd clk edge after enter rises; displays are combinational; no backpressure.
module peripherals_multi
    import periph_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int NUM_OPS    = 2,
    parameter int SPECIAL_EN = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enter,
    input  logic                      loaddata,
    input  logic [7:0]                inputdata,
    input  logic [DATA_W-1:0]         dataR,
    output logic [NUM_OPS*DATA_W-1:0] operands,
    output logic                      inputdata_ready,
    output logic [6:0]                disp3,
    output logic [6:0]                disp2,
    output logic [6:0]                disp1,
    output logic [6:0]                disp0
);

    localparam int BPO     = DATA_W / 8;
    localparam int TOTAL   = NUM_OPS * BPO;
    localparam int IDX_W   = $clog2(TOTAL + 1);
    localparam int PG_W    = $clog2(BPO);
    localparam bit SPEC_ON = (SPECIAL_EN != 0) && (DATA_W == 32);

    logic       enter_s1;
    logic       enter_s2;
    logic       enter_prev;
    logic [1:0] arm_cnt;
    logic       press;

    // arm_cnt keeps the edge detector quiet until enter_prev holds a real sample,
    // so a button held through reset release never counts as a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            enter_s1   <= 1'b0;
            enter_s2   <= 1'b0;
            enter_prev <= 1'b0;
            arm_cnt    <= 2'd0;
        end else begin
            enter_s1   <= enter;
            enter_s2   <= enter_s1;
            enter_prev <= enter_s2;
            if (arm_cnt != 2'd3) arm_cnt <= arm_cnt + 2'd1;
        end
    end

    assign press = enter_s2 & ~enter_prev & (arm_cnt == 2'd3);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [PG_W-1:0]  page;
    logic             ld_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= ST_LOAD;
            idx             <= '0;
            page            <= '0;
            operands        <= '0;
            ld_prev         <= 1'b0;
            inputdata_ready <= 1'b0;
        end else begin
            ld_prev <= loaddata;
            case (state)
                ST_LOAD, ST_FULL: begin
                    if (!loaddata) begin
                        state           <= ST_VIEW;
                        page            <= '0;
                        inputdata_ready <= 1'b1;
                    end else if (state == ST_LOAD && press) begin
                        for (int k = 0; k < TOTAL; k++) begin
                            if (idx == IDX_W'(k)) operands[k*8 +: 8] <= inputdata;
                        end
                        idx <= idx + IDX_W'(1);
                        if (idx == IDX_W'(TOTAL - 1)) begin
                            state           <= ST_FULL;
                            inputdata_ready <= 1'b1;
                        end
                    end
                end
                ST_VIEW: begin
                    if (loaddata && !ld_prev) begin
                        state           <= ST_LOAD;
                        idx             <= '0;
                        page            <= '0;
                        operands        <= '0;
                        inputdata_ready <= 1'b0;
                    end else if (press) begin
                        page <= (page == PG_W'(BPO - 1)) ? '0 : page + PG_W'(1);
                    end
                end
                default: state <= ST_LOAD;
            endcase
        end
    end

    logic [IDX_W-1:0] disp_idx;
    logic [7:0]       cur_byte;
    logic [7:0]       res_byte;
    logic [1:0]       op_k;
    logic [3:0]       byte_k;

    // FULL leaves idx at TOTAL; point the display back at the last byte written.
    always_comb begin
        disp_idx = (state == ST_FULL) ? IDX_W'(TOTAL - 1) : idx;
        cur_byte = '0;
        op_k     = '0;
        byte_k   = '0;
        for (int k = 0; k < TOTAL; k++) begin
            if (disp_idx == IDX_W'(k)) begin
                cur_byte = operands[k*8 +: 8];
                op_k     = 2'(k / BPO);
                byte_k   = 4'(k % BPO);
            end
        end
        res_byte = '0;
        for (int p = 0; p < BPO; p++) begin
            if (page == PG_W'(p)) res_byte = dataR[p*8 +: 8];
        end
    end

    logic   sp_vld;
    glyph_t sp3, sp2, sp1, sp0;

    generate
        if (SPEC_ON) begin : g_special
            always_comb begin
                sp_vld = 1'b1;
                sp3    = G_BLANK;
                sp2    = G_N;
                sp1    = G_A;
                sp0    = G_N;
                case (dataR[31:0])
                    SPC_QNAN_POS: sp3 = G_BLANK;
                    SPC_QNAN_NEG: sp3 = G_MINUS;
                    SPC_INF_POS:  {sp3, sp2, sp1, sp0} = {G_BLANK, G_I, G_N, G_F};
                    SPC_INF_NEG:  {sp3, sp2, sp1, sp0} = {G_MINUS, G_I, G_N, G_F};
                    default:      sp_vld = 1'b0;
                endcase
            end
        end else begin : g_no_special
            assign sp_vld = 1'b0;
            assign sp3    = G_BLANK;
            assign sp2    = G_BLANK;
            assign sp1    = G_BLANK;
            assign sp0    = G_BLANK;
        end
    endgenerate

    glyph_t g3, g2, g1, g0;

    always_comb begin
        g3 = op_letter(op_k);
        g2 = hex_glyph(byte_k);
        g1 = hex_glyph(cur_byte[7:4]);
        g0 = hex_glyph(cur_byte[3:0]);
        if (state == ST_VIEW) begin
            if (sp_vld) begin
                {g3, g2, g1, g0} = {sp3, sp2, sp1, sp0};
            end else begin
                g3 = G_R;
                g2 = hex_glyph(4'(page));
                g1 = hex_glyph(res_byte[7:4]);
                g0 = hex_glyph(res_byte[3:0]);
            end
        end
    end

    periph_glyph7seg u_dig3 (.glyph(g3), .seg(disp3));
    periph_glyph7seg u_dig2 (.glyph(g2), .seg(disp2));
    periph_glyph7seg u_dig1 (.glyph(g1), .seg(disp1));
    periph_glyph7seg u_dig0 (.glyph(g0), .seg(disp0));

endmodule
